gate_sweep_checker: RTL

GATE_SWEEP_CHECKER -- requirements
Module: gate_sweep_checker

---
 rtl/gate_sweep_pkg.sv | 29 ++
 rtl/gate_sweep_checker_if.sv | 30 +++
 rtl/gate_golden.sv | 27 ++
 rtl/gate_sweep_checker.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the exhaustive gate sweep checker:
// gate-function encoding, FSM states and the mode validity helper.
package gate_sweep_pkg;

  typedef enum logic [2:0] {
    MODE_AND   = 3'd0,
    MODE_OR    = 3'd1,
    MODE_XOR   = 3'd2,
    MODE_NAND  = 3'd3,
    MODE_NOR   = 3'd4,
    MODE_XNOR  = 3'd5,
    MODE_RSVD6 = 3'd6,
    MODE_RSVD7 = 3'd7
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [2:0] MODE_LAST_VALID = 3'd5;

  function automatic logic mode_is_valid(input mode_e m);
    return (m <= MODE_LAST_VALID);
  endfunction

endpackage

// File: rtl/gate_sweep_checker_if.sv
// Signal bundle between the sweep checker and the gate it exercises.
// master = checker side, slave = gate/test-harness side.
interface gate_sweep_checker_if #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned ERR_W = 8
);

  logic             start;
  logic [2:0]       mode;
  logic [WIDTH-1:0] stim;
  logic             dut_y;
  logic             busy;
  logic             done;
  logic             pass;
  logic             cfg_err;
  logic [ERR_W-1:0] err_count;
  logic             fail_valid;
  logic [WIDTH-1:0] fail_vec;

  modport master (
    input  start, mode, dut_y,
    output stim, busy, done, pass, cfg_err, err_count, fail_valid, fail_vec
  );

  modport slave (
    output start, mode, dut_y,
    input  stim, busy, done, pass, cfg_err, err_count, fail_valid, fail_vec
  );

endinterface

// File: rtl/gate_golden.sv
// Reference gate: reduction of stim over all bits for the selected function.
// Purely combinational; reserved modes yield 0 (they never reach CHECK).
module gate_golden
  import gate_sweep_pkg::*;
#(
  parameter int unsigned WIDTH = 2
) (
  input  logic [WIDTH-1:0] stim,
  input  mode_e            mode,
  output logic             y_exp
);

  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    y_exp = 1'b0;
    case (mode)
      MODE_AND:  y_exp = &stim;
      MODE_OR:   y_exp = |stim;
      MODE_XOR:  y_exp = ^stim;
      MODE_NAND: y_exp = ~&stim;
      MODE_NOR:  y_exp = ~|stim;
      MODE_XNOR: y_exp = ~^stim;
      default:   y_exp = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_sweep_checker.sv
// Walks stim through every WIDTH-bit vector, holds each for SETTLE cycles,
// then compares the external gate output against the golden reduction.
module gate_sweep_checker
  import gate_sweep_pkg::*;
#(
  parameter int unsigned WIDTH  = 2,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       mode,
  output logic [WIDTH-1:0] stim,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             cfg_err,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [WIDTH-1:0] fail_vec
);

  localparam int unsigned      CNT_W       = $clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [WIDTH-1:0] STIM_LAST   = '1;
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  state_e           state_q,      state_d;
  mode_e            mode_q,       mode_d;
  logic             launch_q,     launch_d;
  logic [WIDTH-1:0] stim_q,       stim_d;
  logic [CNT_W-1:0] settle_q,     settle_d;
  logic [ERR_W-1:0] err_q,        err_d;
  logic             fail_valid_q, fail_valid_d;
  logic [WIDTH-1:0] fail_vec_q,   fail_vec_d;
  logic             cfg_err_q,    cfg_err_d;
  logic             y_exp;

  gate_golden #(.WIDTH(WIDTH)) u_golden (
    .stim  (stim_q),
    .mode  (mode_q),
    .y_exp (y_exp)
  );

  // launch_q marks the cycle between accepting start and acting on the
  // latched mode, so a reserved mode never passes through DRIVE.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    launch_d     = launch_q;
    stim_d       = stim_q;
    settle_d     = settle_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;
    cfg_err_d    = cfg_err_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (launch_q) begin
          launch_d  = 1'b0;
          settle_d  = '0;
          cfg_err_d = !mode_is_valid(mode_q);
          state_d   = mode_is_valid(mode_q) ? ST_DRIVE : ST_DONE;
        end else if (start) begin
          mode_d       = mode_e'(mode);
          launch_d     = 1'b1;
          stim_d       = '0;
          err_d        = '0;
          fail_valid_d = 1'b0;
          fail_vec_d   = '0;
          cfg_err_d    = 1'b0;
          state_d      = ST_IDLE;
        end
      end

      ST_DRIVE: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = '0;
          state_d  = ST_CHECK;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end

      ST_CHECK: begin
        if (dut_y != y_exp) begin
          if (err_q != ERR_MAX) err_d = err_q + 1'b1;
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_vec_d   = stim_q;
          end
        end
        if (stim_q == STIM_LAST) begin
          state_d = ST_DONE;
        end else begin
          stim_d  = stim_q + 1'b1;
          state_d = ST_DRIVE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_AND;
      launch_q     <= 1'b0;
      stim_q       <= '0;
      settle_q     <= '0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      launch_q     <= launch_d;
      stim_q       <= stim_d;
      settle_q     <= settle_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign stim       = stim_q;
  assign busy       = (state_q == ST_DRIVE) || (state_q == ST_CHECK);
  assign done       = (state_q == ST_DONE);
  assign pass       = done && (err_q == '0) && !cfg_err_q;
  assign cfg_err    = cfg_err_q;
  assign err_count  = err_q;
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;

endmodule
